// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause field positions.
// Register helpers assemble the architectural 32-bit views from the stored fields.
package cp0_exc_unit_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD_BIT = 31;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r = '0;
    r[SR_IM_LO +: 6] = im;
    r[SR_EXL_BIT]    = exl;
    r[SR_IE_BIT]     = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] r;
    r = '0;
    r[CAUSE_BD_BIT]       = bd;
    r[CAUSE_IP_LO +: 6]   = ip;
    r[CAUSE_EXC_LO +: 5]  = exc;
    return r;
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Combinational request arbitration: decides whether the M-stage instruction is
// preempted and which ExcCode gets recorded. Interrupts win over synchronous exceptions.
module cp0_int_arb
  import cp0_exc_unit_pkg::*;
(
  input  logic       sr_ie_i,
  input  logic       sr_exl_i,
  input  logic [5:0] sr_im_i,
  input  logic [5:0] hw_int_i,
  input  logic [4:0] exc_code_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       req_o,
  output logic [4:0] code_o
);

  always_comb begin
    int_req_o = sr_ie_i & ~sr_exl_i & (|(hw_int_i & sr_im_i));
    exc_req_o = (exc_code_i != 5'd0) & ~sr_exl_i;
    req_o     = int_req_o | exc_req_o;
    code_o    = int_req_o ? EXC_INT : exc_code_i;
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller at the M stage: raises Req to flush the pipe,
// records EPC/Cause, and services mfc0/mtc0 on SR, Cause, EPC and PRId.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2021_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] HandlerPC,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req, exc_req, req;
  logic [4:0]  sel_code;
  logic [31:0] victim_pc;

  cp0_int_arb u_arb (
    .sr_ie_i    (sr_ie_q),
    .sr_exl_i   (sr_exl_q),
    .sr_im_i    (sr_im_q),
    .hw_int_i   (HWInt),
    .exc_code_i (ExcCodeIn),
    .int_req_o  (int_req),
    .exc_req_o  (exc_req),
    .req_o      (req),
    .code_o     (sel_code)
  );

  // A delay-slot victim restarts at its branch so the branch is re-executed.
  assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = BDIn;
      cause_exc_d = sel_code;
      epc_d       = victim_pc & ~32'h3;
    end else begin
      if (WE) begin
        case (A2)
          CP0_SR: begin
            sr_im_d  = DIn[SR_IM_LO +: 6];
            sr_exl_d = DIn[SR_EXL_BIT];
            sr_ie_d  = DIn[SR_IE_BIT];
          end
          CP0_EPC: epc_d = DIn;
          default: ;
        endcase
      end
      // eret clears EXL after any same-cycle mtc0 SR value has been applied.
      if (EXLClr) sr_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    case (A1)
      CP0_SR:    DOut = pack_sr(sr_im_q, sr_exl_q, sr_ie_q);
      CP0_CAUSE: DOut = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
      CP0_EPC:   DOut = epc_q;
      CP0_PRID:  DOut = PRID_VAL;
      default:   DOut = 32'd0;
    endcase
  end

  assign Req       = req;
  assign HandlerPC = HANDLER_ADDR;
  assign EPCOut    = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: hand-computed expectations for reset, interrupt,
// delay-slot exception, masking, misaligned EPC, eret and mtc0/Req collisions.
module tb_cp0_exc_unit;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2021_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] HandlerPC, EPCOut, DOut;

  int checks = 0;
  int errors = 0;

  cp0_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .Req       (Req),
    .HandlerPC (HandlerPC),
    .EPCOut    (EPCOut),
    .DOut      (DOut)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    WE = 1'b0; A2 = 5'd0; DIn = '0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] num, input logic [31:0] exp);
    A1 = num;
    #1;
    check(tag, DOut, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, Req}, {31'd0, exp});
  endtask

  task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
    WE = 1'b1; A2 = num; DIn = data;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b0; A1 = 5'd12; VPC = '0;
    idle();
    step(); step();
    chk_reg("rst_sr", 5'd12, 32'h0);
    chk_reg("rst_cause", 5'd13, 32'h0);
    chk_reg("rst_epc", 5'd14, 32'h0);
    chk_reg("rst_prid", 5'd15, PRID);
    check("rst_epcout", EPCOut, 32'h0);
    reset = 1'b1;
    chk_req("rst_req", 1'b0);
    check("handler_pc", HandlerPC, HANDLER);
    step();

    // interrupt
    mtc0(5'd12, 32'h0000_0401);
    chk_reg("no_bypass_sr", 5'd12, 32'h0);
    step(); idle();
    chk_reg("mtc0_sr", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; VPC = 32'h3010;
    chk_req("int_req", 1'b1);
    step(); idle();
    chk_reg("int_epc", 5'd14, 32'h3010);
    check("int_epcout", EPCOut, 32'h3010);
    chk_reg("int_sr", 5'd12, 32'h0000_0403);
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    eret();
    chk_reg("eret1_sr", 5'd12, 32'h0000_0401);

    // delay-slot overflow
    ExcCodeIn = 5'd12; VPC = 32'h3024; BDIn = 1'b1;
    chk_req("ov_req", 1'b1);
    step(); idle();
    chk_reg("ov_epc", 5'd14, 32'h3020);
    chk_reg("ov_cause", 5'd13, 32'h8000_0030);

    // masked while EXL=1
    ExcCodeIn = 5'd4; HWInt = 6'h3F; VPC = 32'h3100;
    chk_req("mask_req", 1'b0);
    step(); idle();
    chk_reg("mask_epc", 5'd14, 32'h3020);
    chk_reg("mask_cause", 5'd13, 32'h8000_FC30);
    eret();
    chk_reg("eret2_sr", 5'd12, 32'h0000_0401);
    chk_reg("eret2_cause", 5'd13, 32'h8000_0030);

    // misaligned fetch records an aligned EPC
    ExcCodeIn = 5'd4; VPC = 32'h3003;
    chk_req("adel_req", 1'b1);
    step(); idle();
    chk_reg("adel_epc", 5'd14, 32'h3000);
    chk_reg("adel_cause", 5'd13, 32'h0000_0010);
    chk_reg("adel_sr", 5'd12, 32'h0000_0403);
    eret();
    chk_reg("eret3_sr", 5'd12, 32'h0000_0401);

    // EXLClr together with Req: Req wins
    EXLClr = 1'b1; ExcCodeIn = 5'd10; VPC = 32'h3008;
    chk_req("clr_req", 1'b1);
    step(); idle();
    chk_reg("clr_sr", 5'd12, 32'h0000_0403);
    chk_reg("clr_cause", 5'd13, 32'h0000_0028);
    chk_reg("clr_epc", 5'd14, 32'h3008);
    eret();

    // mtc0 EPC collides with Req: write dropped
    mtc0(5'd14, 32'h5000); ExcCodeIn = 5'd12; VPC = 32'h3040;
    chk_req("coll_req", 1'b1);
    step(); idle();
    chk_reg("coll_epc", 5'd14, 32'h3040);
    eret();
    mtc0(5'd14, 32'h5000);
    chk_req("wr_req", 1'b0);
    step(); idle();
    chk_reg("wr_epc", 5'd14, 32'h5000);
    check("wr_epcout", EPCOut, 32'h5000);

    // Cause and PRId are read-only
    mtc0(5'd13, 32'hFFFF_FFFF);
    step(); idle();
    chk_reg("ro_cause", 5'd13, 32'h0000_0030);
    mtc0(5'd15, 32'h0);
    step(); idle();
    chk_reg("ro_prid", 5'd15, PRID);
    chk_reg("unmapped", 5'd3, 32'h0);

    // SR write masking, then mtc0 SR with EXLClr in the same cycle
    mtc0(5'd12, 32'hFFFF_FFFF);
    step(); idle();
    chk_reg("sr_mask", 5'd12, 32'h0000_FC03);
    mtc0(5'd12, 32'h0000_0403); EXLClr = 1'b1;
    step(); idle();
    chk_reg("sr_clr", 5'd12, 32'h0000_0401);

    // reset mid-operation beats Req and WE
    ExcCodeIn = 5'd12; VPC = 32'h3100; mtc0(5'd14, 32'h1234);
    chk_req("midrst_req", 1'b1);
    reset = 1'b0;
    step(); idle(); reset = 1'b1;
    chk_reg("midrst_sr", 5'd12, 32'h0);
    chk_reg("midrst_cause", 5'd13, 32'h0);
    chk_reg("midrst_epc", 5'd14, 32'h0);
    chk_req("midrst_req_after", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
